stream_mux_rr: RTL and testbench

Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes, a registered output stage and two selection modes: fixed (externally selected channel) and round-robin. It is the sequential successor of the fixed 4-channel combinational data mux. It sits between several producer streams and a single consumer and merges them without dropping or duplicating beats.

---
 rtl/stream_mux_rr.sv | 121 ++++++++++++
 tb/tb_stream_mux_rr.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a single registered output stage.
// Channel selection is either fixed (sel) or round-robin starting from a rotating pointer.
module stream_mux_rr #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  localparam int SW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  input  logic               rr_en,
  input  logic [SW-1:0]      sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_sel,
  input  logic               out_ready
);

  logic [N-1:0]     grant_s;
  logic [SW-1:0]    grant_idx_s;
  logic             found_s;
  logic [SW:0]      sum_s;
  logic [WIDTH-1:0] load_data_s;
  logic             can_load_s;
  logic             xfer_s;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [SW-1:0]    ptr_q, ptr_d;

  // Grant selection; the round-robin index is wrapped at N so non-power-of-two N never reaches unused codes
  always_comb begin
    grant_s     = {N{1'b0}};
    grant_idx_s = {SW{1'b0}};
    found_s     = 1'b0;
    sum_s       = {(SW+1){1'b0}};
    if (rr_en) begin
      for (int j = 0; j < N; j++) begin
        sum_s = {1'b0, ptr_q} + (SW+1)'(j);
        if (sum_s >= (SW+1)'(N)) begin
          sum_s = sum_s - (SW+1)'(N);
        end else begin
          sum_s = sum_s;
        end
        if (!found_s && in_valid[sum_s[SW-1:0]]) begin
          grant_s[sum_s[SW-1:0]] = 1'b1;
          grant_idx_s            = sum_s[SW-1:0];
          found_s                = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end else if ({1'b0, sel} < (SW+1)'(N)) begin
      grant_s[sel] = in_valid[sel];
      grant_idx_s  = sel;
    end else begin
      grant_s = {N{1'b0}};
    end
  end

  assign can_load_s = ~valid_q | out_ready;
  assign in_ready   = grant_s & {N{can_load_s & ~rst}};
  assign xfer_s     = |in_ready;

  // Data of the granted channel
  always_comb begin
    load_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (grant_s[i]) begin
        load_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        load_data_s = load_data_s;
      end
    end
  end

  // Next state of the output register and round-robin pointer
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (xfer_s) begin
      valid_d = 1'b1;
      data_d  = load_data_s;
      sel_d   = grant_idx_s;
      if (rr_en) begin
        ptr_d = (grant_idx_s == SW'(N - 1)) ? {SW{1'b0}} : grant_idx_s + SW'(1);
      end else begin
        ptr_d = ptr_q;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers; reset discards any held beat
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
      sel_q   <= {SW{1'b0}};
      ptr_q   <= {SW{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: a 4x4 instance driven against a reference model,
// and a 3x8 instance checked for wrap-around and out-of-range fixed select.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  in_valid_a, in_ready_a;
  logic [15:0] in_data_a;
  logic        rr_en_a, out_valid_a, out_ready_a;
  logic [1:0]  sel_a, out_sel_a;
  logic [3:0]  out_data_a;

  logic [2:0]  in_valid_b, in_ready_b;
  logic [23:0] in_data_b;
  logic        rr_en_b, out_valid_b, out_ready_b;
  logic [1:0]  sel_b, out_sel_b;
  logic [7:0]  out_data_b;

  stream_mux_rr #(.WIDTH(4), .N(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
    .rr_en(rr_en_a), .sel(sel_a), .out_valid(out_valid_a), .out_data(out_data_a),
    .out_sel(out_sel_a), .out_ready(out_ready_a));

  stream_mux_rr #(.WIDTH(8), .N(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .rr_en(rr_en_b), .sel(sel_b), .out_valid(out_valid_b), .out_data(out_data_b),
    .out_sel(out_sel_b), .out_ready(out_ready_b));

  int         n_cmp = 0;
  int         n_err = 0;
  int         ptr_m;
  bit         exp_valid_m;
  bit         was_reset_m;
  int         q_sel[$];
  logic [3:0] q_data[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant(input bit rr, input logic [1:0] s, input logic [3:0] v, input int p);
    if (!rr) return v[s] ? int'(s) : -1;
    for (int j = 0; j < 4; j++) begin
      if (v[(p + j) % 4]) return (p + j) % 4;
    end
    return -1;
  endfunction

  // One clock of instance A: check at negedge against the model, then advance the model at posedge
  task automatic step_a();
    int         g;
    bit         can;
    logic [3:0] exp_ready;
    @(negedge clk);
    g         = model_grant(rr_en_a, sel_a, in_valid_a, ptr_m);
    can       = !exp_valid_m || out_ready_a;
    exp_ready = (g >= 0 && can && !rst) ? 4'(32'd1 << g) : 4'd0;
    check_val("in_ready", 32'(in_ready_a), 32'(exp_ready));
    check_val("out_valid", 32'(out_valid_a), 32'(exp_valid_m));
    if (was_reset_m) begin
      check_val("rst_data", 32'(out_data_a), 32'd0);
      check_val("rst_sel", 32'(out_sel_a), 32'd0);
    end
    if (out_valid_a) begin
      if (q_sel.size() == 0) begin
        check_val("sb_empty", 32'd1, 32'd0);
      end else begin
        check_val("out_sel", 32'(out_sel_a), 32'(q_sel[0]));
        check_val("out_data", 32'(out_data_a), 32'(q_data[0]));
      end
    end
    @(posedge clk);
    was_reset_m = 1'b0;
    if (rst) begin
      ptr_m = 0; exp_valid_m = 1'b0; was_reset_m = 1'b1;
      q_sel.delete(); q_data.delete();
    end else begin
      if (exp_valid_m && out_ready_a && q_sel.size() > 0) begin
        void'(q_sel.pop_front()); void'(q_data.pop_front());
      end
      if (exp_ready != 4'd0) begin
        q_sel.push_back(g);
        q_data.push_back(in_data_a[g*4 +: 4]);
        exp_valid_m = 1'b1;
        if (rr_en_a) ptr_m = (g == 3) ? 0 : g + 1;
      end else if (exp_valid_m && out_ready_a) begin
        exp_valid_m = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid_a = 4'd0; in_data_a = 16'd0; rr_en_a = 1'b0; sel_a = 2'd0; out_ready_a = 1'b1;
    in_valid_b = 3'd0; in_data_b = 24'd0; rr_en_b = 1'b0; sel_b = 2'd0; out_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ptr_m = 0; exp_valid_m = 1'b0; was_reset_m = 1'b1;
    rst = 1'b0;

    // Fixed mode: sel stepped 0..3 with all channels valid
    in_valid_a = 4'hF; in_data_a = 16'hDCBA;
    for (int s = 0; s < 4; s++) begin
      sel_a = 2'(s);
      step_a();
    end
    in_valid_a = 4'h0;
    step_a();

    // Round-robin with all channels valid
    rr_en_a = 1'b1; in_valid_a = 4'hF;
    for (int c = 0; c < 10; c++) begin
      in_data_a = 16'($urandom);
      step_a();
    end

    // Round-robin from ptr=0 with only ch1 and ch3, then ch1 alone
    rst = 1'b1; step_a(); rst = 1'b0;
    in_valid_a = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      in_data_a = 16'($urandom);
      step_a();
    end
    in_valid_a = 4'b0010;
    repeat (3) step_a();

    // Backpressure with beat 5 held
    rr_en_a = 1'b0; sel_a = 2'd1; in_data_a = 16'h0050; out_ready_a = 1'b1;
    step_a();
    out_ready_a = 1'b0; in_data_a = 16'h0060;
    repeat (3) step_a();
    out_ready_a = 1'b1;
    repeat (2) step_a();

    // Reset mid-stream with ptr at 2
    in_valid_a = 4'h0; step_a();
    rst = 1'b1; step_a(); rst = 1'b0;
    rr_en_a = 1'b1; in_valid_a = 4'hF;
    repeat (2) step_a();
    rst = 1'b1; step_a(); rst = 1'b0;
    repeat (2) step_a();

    // Random traffic, mode and select changes, occasional reset
    for (int c = 0; c < 300; c++) begin
      in_valid_a  = 4'($urandom);
      in_data_a   = 16'($urandom);
      rr_en_a     = 1'($urandom_range(0, 1));
      sel_a       = 2'($urandom);
      out_ready_a = ($urandom_range(0, 3) != 0);
      rst         = ($urandom_range(0, 39) == 0);
      step_a();
    end
    rst = 1'b0; in_valid_a = 4'h0;

    // N=3 instance: round-robin wrap at 3
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    rr_en_b = 1'b1; in_valid_b = 3'b111; in_data_b = 24'h332211; out_ready_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val("b_ready", 32'(in_ready_b), 32'd1 << (c % 3));
      check_val("b_valid", 32'(out_valid_b), (c > 0) ? 32'd1 : 32'd0);
      if (c > 0) begin
        check_val("b_sel", 32'(out_sel_b), 32'((c - 1) % 3));
        check_val("b_data", 32'(out_data_b), 32'(8'h11) * 32'((c - 1) % 3 + 1));
      end
      @(posedge clk); #1;
    end

    // N=3 instance: fixed select out of range grants nothing
    rr_en_b = 1'b0; sel_b = 2'd3;
    @(negedge clk);
    check_val("b_oor_ready", 32'(in_ready_b), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("b_oor_ready2", 32'(in_ready_b), 32'd0);
    check_val("b_oor_valid", 32'(out_valid_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
